// File: rtl/cpu_pkg.sv
// Shared CPU definitions: jump-condition encodings, fetch FSM states,
// the default NOP word and status-flag bit positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        JNE = 3'b000,
        JEQ = 3'b001,
        JNC = 3'b010,
        JC  = 3'b011,
        JN  = 3'b100,
        JGE = 3'b101,
        JL  = 3'b110,
        JMP = 3'b111
    } jp_cond_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam logic [15:0] NOP_INSN_DEFAULT = 16'h4303;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory read port between the fetch stage and memory.
// Handshake: the master raises mem_req with mem_addr and holds both stable
// until it samples mem_ack=1 on a rising edge; mem_rdata is valid in that
// same cycle, after which mem_req drops. mem_ack outside a request is ignored.
interface fetch_pc_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_pc_unit_branch_cond.sv
// Combinational jump-condition evaluator: decides whether a jump is taken
// from the condition select and the {N,Z,C,V} status flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] jp_cond,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (jp_cond_t'(jp_cond))
            JNE:     taken = ~flags[FLAG_Z];
            JEQ:     taken =  flags[FLAG_Z];
            JNC:     taken = ~flags[FLAG_C];
            JC:      taken =  flags[FLAG_C];
            JN:      taken =  flags[FLAG_N];
            JGE:     taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            JL:      taken =  (flags[FLAG_N] ^ flags[FLAG_V]);
            JMP:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-word instruction fetch stage. The PC update path
// runs independently of the fetch FSM; the fetch address is latched at start.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 8,
    parameter logic [15:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_req,
    input  logic                   en_pc_2,
    input  logic                   branch_en,
    input  logic                   pc_inc,
    input  logic [9:0]             pc_offset,
    input  logic [2:0]             jp_cond,
    input  logic [3:0]             flags,
    fetch_pc_unit_if.master        mem,
    output logic [15:0]            instruction,
    output logic                   inst_valid,
    output logic                   fetch_err,
    output logic [15:0]            pc,
    output logic                   branch_taken,
    output fetch_state_t           fetch_state
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t state, state_next;
    logic [7:0]   wait_cnt;
    logic         start_fetch;
    logic         ack_hit;
    logic         time_out;
    logic         mem_req_q;
    logic [15:0]  mem_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_fetch = 1'b0;
        ack_hit     = 1'b0;
        time_out    = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    start_fetch = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    ack_hit    = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    time_out   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 16'h0000;
            wait_cnt    <= 8'd0;
            instruction <= 16'h0000;
            inst_valid  <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            inst_valid <= ack_hit;
            fetch_err  <= time_out;
            if (start_fetch) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= pc;
                wait_cnt   <= 8'd0;
            end else if (ack_hit || time_out) begin
                mem_req_q <= 1'b0;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (ack_hit)       instruction <= mem.mem_rdata;
            else if (time_out) instruction <= NOP_INSN;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign fetch_state  = state;

    logic        cond_taken;
    logic        inc_pending;
    logic        inc_go;
    logic        jump_go;
    logic [15:0] pc_seq;
    logic [15:0] offset_ext;
    logic [15:0] pc_next;

    branch_cond u_branch_cond (
        .jp_cond (jp_cond),
        .flags   (flags),
        .taken   (cond_taken)
    );

    // Word offset is sign-extended and scaled to bytes in one concatenation.
    assign offset_ext = {{5{pc_offset[9]}}, pc_offset, 1'b0};
    assign inc_go     = pc_inc & (inc_pending | en_pc_2);
    assign jump_go    = branch_en & cond_taken;
    assign pc_seq     = pc + 16'd2;
    assign pc_next    = jump_go ? (pc_seq + offset_ext) : pc_seq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC & 16'hFFFE;
            inc_pending  <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            branch_taken <= inc_go & jump_go;
            if (inc_go) begin
                pc          <= pc_next & 16'hFFFE;
                inc_pending <= 1'b0;
            end else if (en_pc_2) begin
                inc_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, fetch handshake, timeout,
// PC increment, conditional jumps, wrap-around and fetch/PC overlap.
module tb_fetch_pc_unit;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_req;
    logic         en_pc_2;
    logic         branch_en;
    logic         pc_inc;
    logic [9:0]   pc_offset;
    logic [2:0]   jp_cond;
    logic [3:0]   flags;
    logic [15:0]  instruction;
    logic         inst_valid;
    logic         fetch_err;
    logic [15:0]  pc;
    logic         branch_taken;
    fetch_state_t fetch_state;

    int check_count = 0;
    int error_count = 0;

    fetch_pc_unit_if mem ();

    fetch_pc_unit #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (8),
        .NOP_INSN (16'h4303)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .en_pc_2      (en_pc_2),
        .branch_en    (branch_en),
        .pc_inc       (pc_inc),
        .pc_offset    (pc_offset),
        .jp_cond      (jp_cond),
        .flags        (flags),
        .mem          (mem),
        .instruction  (instruction),
        .inst_valid   (inst_valid),
        .fetch_err    (fetch_err),
        .pc           (pc),
        .branch_taken (branch_taken),
        .fetch_state  (fetch_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check_count++;
        assert (obs === exp) else begin
            error_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pc_step(input logic en, input logic inc, input logic br,
                           input logic [9:0] off, input logic [2:0] cond, input logic [3:0] fl);
        en_pc_2   = en;
        pc_inc    = inc;
        branch_en = br;
        pc_offset = off;
        jp_cond   = cond;
        flags     = fl;
        tick();
        en_pc_2   = 1'b0;
        pc_inc    = 1'b0;
        branch_en = 1'b0;
        pc_offset = 10'h000;
        jp_cond   = 3'b000;
        flags     = 4'b0000;
    endtask

    // Arm with en_pc_2, then commit with pc_inc carrying the jump fields.
    task automatic jump(input logic br, input logic [9:0] off, input logic [2:0] cond, input logic [3:0] fl);
        pc_step(1'b1, 1'b0, 1'b0, 10'h000, 3'b000, 4'b0000);
        pc_step(1'b0, 1'b1, br, off, cond, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        rst = 1'b1; fetch_req = 1'b0; en_pc_2 = 1'b0; branch_en = 1'b0; pc_inc = 1'b0;
        pc_offset = 10'h000; jp_cond = 3'b000; flags = 4'b0000;
        mem.mem_ack = 1'b0; mem.mem_rdata = 16'h0000;
        do_reset();

        check("reset_pc", pc, 16'h0000);
        check("reset_instruction", instruction, 16'h0000);
        check("reset_mem_req", 16'(mem.mem_req), 16'h0);
        check("reset_mem_addr", mem.mem_addr, 16'h0000);
        check("reset_inst_valid", 16'(inst_valid), 16'h0);
        check("reset_fetch_err", 16'(fetch_err), 16'h0);
        check("reset_branch_taken", 16'(branch_taken), 16'h0);
        check("reset_state", 16'(fetch_state), 16'(IDLE));

        // Zero-wait fetch at 0000
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("seq_mem_req", 16'(mem.mem_req), 16'h1);
        check("seq_mem_addr", mem.mem_addr, 16'h0000);
        check("seq_valid_early", 16'(inst_valid), 16'h0);
        check("seq_state_req", 16'(fetch_state), 16'(REQ));
        mem.mem_ack = 1'b1; mem.mem_rdata = 16'h5405;
        tick();
        mem.mem_ack = 1'b0;
        check("seq_inst_valid", 16'(inst_valid), 16'h1);
        check("seq_instruction", instruction, 16'h5405);
        check("seq_mem_req_drop", 16'(mem.mem_req), 16'h0);
        tick();
        check("seq_valid_pulse_end", 16'(inst_valid), 16'h0);
        check("seq_state_idle", 16'(fetch_state), 16'(IDLE));

        pc_step(1'b1, 1'b0, 1'b0, 10'h000, 3'b000, 4'b0000);
        check("arm_only_pc", pc, 16'h0000);
        pc_step(1'b0, 1'b1, 1'b0, 10'h000, 3'b000, 4'b0000);
        check("inc_pc", pc, 16'h0002);
        pc_step(1'b0, 1'b1, 1'b0, 10'h000, 3'b000, 4'b0000);
        check("inc_no_pending_pc", pc, 16'h0002);

        // mem_ack outside REQ
        mem.mem_ack = 1'b1; mem.mem_rdata = 16'h1111;
        tick();
        mem.mem_ack = 1'b0;
        check("idle_ack_valid", 16'(inst_valid), 16'h0);
        check("idle_ack_instruction", instruction, 16'h5405);

        // Reset asserted in the middle of REQ
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("rst_mid_state_req", 16'(fetch_state), 16'(REQ));
        mem.mem_ack = 1'b1; mem.mem_rdata = 16'h7777;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 16'(mem.mem_req), 16'h0);
        check("rst_mid_pc", pc, 16'h0000);
        check("rst_mid_instruction", instruction, 16'h0000);
        check("rst_mid_inst_valid", 16'(inst_valid), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_release_valid_1", 16'(inst_valid), 16'h0);
        tick();
        check("rst_release_valid_2", 16'(inst_valid), 16'h0);
        check("rst_release_instruction", instruction, 16'h0000);
        check("rst_release_state", 16'(fetch_state), 16'(IDLE));
        mem.mem_ack = 1'b0;

        // Same-cycle arm+commit gives one increment each
        for (int i = 0; i < 8; i++) pc_step(1'b1, 1'b1, 1'b0, 10'h000, 3'b000, 4'b0000);
        check("combined_inc_pc", pc, 16'h0010);

        jump(1'b1, 10'h3FF, 3'b111, 4'b0000);
        check("jmp_back1_pc", pc, 16'h0010);
        check("jmp_back1_taken", 16'(branch_taken), 16'h1);
        tick();
        check("jmp_taken_pulse_end", 16'(branch_taken), 16'h0);
        jump(1'b1, 10'h200, 3'b111, 4'b0000);
        check("jmp_back512_pc", pc, 16'hFC12);
        check("jmp_back512_taken", 16'(branch_taken), 16'h1);

        do_reset();
        jump(1'b1, 10'h00F, 3'b111, 4'b0000);
        check("jmp_fwd_pc", pc, 16'h0020);
        jump(1'b1, 10'h005, 3'b001, 4'b0000);
        check("jeq_z0_pc", pc, 16'h0022);
        check("jeq_z0_taken", 16'(branch_taken), 16'h0);
        jump(1'b1, 10'h005, 3'b001, 4'b0100);
        check("jeq_z1_pc", pc, 16'h002E);
        check("jeq_z1_taken", 16'(branch_taken), 16'h1);
        jump(1'b1, 10'h3FE, 3'b110, 4'b1000);
        check("jl_pc", pc, 16'h002C);
        jump(1'b1, 10'h3FE, 3'b101, 4'b1000);
        check("jge_not_pc", pc, 16'h002E);
        jump(1'b1, 10'h010, 3'b010, 4'b0010);
        check("jnc_not_pc", pc, 16'h0030);
        jump(1'b0, 10'h0FF, 3'b111, 4'b0000);
        check("no_branch_en_pc", pc, 16'h0032);
        check("no_branch_en_taken", 16'(branch_taken), 16'h0);

        // Timeout with mem_ack held low
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("to_mem_addr", mem.mem_addr, 16'h0032);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (fetch_err) break;
            if (mem.mem_req) req_cycles++;
            tick();
        end
        check("to_req_cycles", 16'(req_cycles), 16'd8);
        check("to_fetch_err", 16'(fetch_err), 16'h1);
        check("to_instruction", instruction, 16'h4303);
        check("to_inst_valid", 16'(inst_valid), 16'h0);
        check("to_mem_req", 16'(mem.mem_req), 16'h0);
        tick();
        check("to_err_pulse_end", 16'(fetch_err), 16'h0);
        check("to_state_idle", 16'(fetch_state), 16'(IDLE));

        // Wrap at top of address space
        do_reset();
        jump(1'b1, 10'h3FE, 3'b111, 4'b0000);
        check("wrap_pre_pc", pc, 16'hFFFE);
        pc_step(1'b1, 1'b1, 1'b0, 10'h000, 3'b000, 4'b0000);
        check("wrap_pc", pc, 16'h0000);

        // PC update and extra fetch_req during an in-flight fetch
        fetch_req = 1'b1;
        tick();
        check("ovl_state_req", 16'(fetch_state), 16'(REQ));
        check("ovl_mem_addr", mem.mem_addr, 16'h0000);
        en_pc_2 = 1'b1; pc_inc = 1'b1;
        tick();
        fetch_req = 1'b0; en_pc_2 = 1'b0; pc_inc = 1'b0;
        check("ovl_pc", pc, 16'h0002);
        check("ovl_mem_addr_held", mem.mem_addr, 16'h0000);
        check("ovl_mem_req_held", 16'(mem.mem_req), 16'h1);
        mem.mem_ack = 1'b1; mem.mem_rdata = 16'hABCD;
        tick();
        mem.mem_ack = 1'b0;
        check("ovl_instruction", instruction, 16'hABCD);
        check("ovl_inst_valid", 16'(inst_valid), 16'h1);
        tick();
        check("ovl_state_idle", 16'(fetch_state), 16'(IDLE));
        tick();
        check("ovl_no_refetch_req", 16'(mem.mem_req), 16'h0);
        check("ovl_no_refetch_state", 16'(fetch_state), 16'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
